seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Parametrised, multi-cycle shift/rotate unit. It is the successor to the fixed 16-bit, single-position, left-only shift used by the pseudo-random datapath.
- Shifts by a runtime amount, one bit position per clock.
- Supports logical, arithmetic and rotate modes.
- Uses a start/busy/done handshake, so the controller FSM or the PRNG sequencer can issue variable shifts without a barrel shifter.

Parameters:
- WIDTH, 16, operand/result width in bits (≥2).
- AMT_W, 4, width of the shift-amount port; must satisfy 2**AMT_W ≥ WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- mode  input  3  operation: 0 SHL, 1 SHR (logical), 2 ASR, 3 ROL, 4 ROR; 5-7 reserved, treated as pass-through.
- amount  input  AMT_W  number of bit positions, 0..2**AMT_W-1.
- din  input  WIDTH  operand.
- busy  output  1  high while state=SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- dout  output  WIDTH  working/result register.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0; done=0; dout=0; count=0; latched mode=0.
  - Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 → latch din into dout, latch mode, count=amount. Next state is DONE if amount=0, else SHIFT.
  - SHIFT: each edge applies one single-bit step per the latched mode and decrements count. When count=1 at that edge, next state is DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted, back-to-back, with the same load rules as IDLE.
    - Otherwise next state is IDLE.
- Latency: start sampled at edge k → done high in the cycle following edge k+amount. Throughput is one result per amount+1 cycles.
- start while busy=1 is ignored; inputs are not re-sampled.
- Inputs are latched at acceptance; later changes to din/mode/amount have no effect.
- dout is updated every SHIFT cycle, so intermediate values are visible. It is valid only when done=1, and holds unchanged in IDLE until the next accepted start.
- Single-bit step rules:
  - SHL: {x[W-2:0],0}.
  - SHR: {0,x[W-1:1]}.
  - ASR: {x[W-1],x[W-1:1]}.
  - ROL: {x[W-2:0],x[W-1]}.
  - ROR: {x[0],x[W-1:1]}.
  - Reserved modes: x unchanged, but still consume amount cycles.
- amount ≥ WIDTH: SHL/SHR yield 0, ASR yields all sign bits, and rotates wrap modulo WIDTH (naturally, by stepping).

Optional Feature:
- Macro SEQ_SHIFTER_CARRY_EN.
- Defined:
  - Adds output port carry (1 bit, reset 0).
  - Each SHIFT step loads carry with the bit shifted or rotated out: x[W-1] for SHL/ROL, x[0] for SHR/ASR/ROR, 0 for reserved modes.
  - An accepted start clears carry, so amount=0 gives carry=0.
  - carry is valid alongside done and held with dout.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package shift_pkg holds:
  - Mode constants MODE_SHL=3'd0 … MODE_ROR=3'd4.
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module, shift_step: purely combinational, parametrised by WIDTH. Inputs x and mode; outputs y and out_bit. It generalises the existing fixed left-shift, and is instantiated once in seq_shifter.

Test Plan:
- SHL, amount=1, din=16'hC001 → done after edge k+1; dout=16'h8002; carry=1 (macro on).
- ASR, amount=4, din=16'h8000 → done after edge k+4; dout=16'hF800; busy high for 4 cycles.
- ROR, amount=15, din=16'h0001 → dout=16'h0002 at done (after edge k+15); carry=0.
- SHR, amount=0, din=16'hABCD → done in cycle after edge k; dout=16'hABCD; busy never asserts; carry=0.
- ROL, amount=8, din=16'h1234:
  - Pulse start with din=16'hFFFF at cycle k+3 → ignored; result 16'h3412.
  - Then assert rst_n=0 at k+4 of a new run → busy=0, dout=0, no done pulse.
- Back-to-back: assert start during DONE with mode=7, amount=2, din=16'h5A5A → accepted immediately; done again 2 edges later with dout=16'h5A5A.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg: shared definitions for the seq_shifter block.
//   - MODE_* : operation encodings on the 3-bit mode input
//              (values 5..7 are reserved and act as pass-through).
//   - state_t: FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE).
// Optional feature macro used by the block: SEQ_SHIFTER_CARRY_EN.
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam logic [2:0] MODE_SHL = 3'd0;
    localparam logic [2:0] MODE_SHR = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// ---------------------------------------------------------------------------
// seq_shifter_if: start/busy/done handshake and data bus of seq_shifter.
//   start  : request (controller -> shifter)
//   mode   : operation select, see shift_pkg MODE_*
//   amount : shift distance in bit positions
//   din    : operand
//   busy   : shifter is stepping
//   done   : one-cycle result-valid pulse
//   dout   : working/result register
//   carry  : last bit shifted/rotated out (only with SEQ_SHIFTER_CARRY_EN)
// Modports: master (controller side), slave (shifter side).
// ---------------------------------------------------------------------------
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
`ifdef SEQ_SHIFTER_CARRY_EN
    logic             carry;
`endif

    modport master (
        output start, mode, amount, din,
`ifdef SEQ_SHIFTER_CARRY_EN
        input  carry,
`endif
        input  busy, done, dout
    );

    modport slave (
        input  start, mode, amount, din,
`ifdef SEQ_SHIFTER_CARRY_EN
        output carry,
`endif
        output busy, done, dout
    );
endinterface

// File: rtl/seq_shifter_step.sv
// ---------------------------------------------------------------------------
// shift_step: purely combinational single-position shift/rotate.
//   x       : operand
//   mode    : operation select (shift_pkg MODE_*; 5..7 pass-through)
//   y       : operand moved by one bit position
//   out_bit : bit leaving the word (0 for pass-through modes)
// Generalises the old fixed 16-bit left-by-one shift to any WIDTH >= 2.
// ---------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] y,
    output logic             out_bit
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        y       = x;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin y = {x[WIDTH-2:0], 1'b0};       out_bit = x[WIDTH-1]; end
            MODE_SHR: begin y = {1'b0, x[WIDTH-1:1]};       out_bit = x[0];       end
            MODE_ASR: begin y = {x[WIDTH-1], x[WIDTH-1:1]}; out_bit = x[0];       end
            MODE_ROL: begin y = {x[WIDTH-2:0], x[WIDTH-1]}; out_bit = x[WIDTH-1]; end
            MODE_ROR: begin y = {x[0], x[WIDTH-1:1]};       out_bit = x[0];       end
            default:  ; // reserved modes: pass-through
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter: multi-cycle shift/rotate unit, one bit position per clock.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : seq_shifter_if.slave (start/mode/amount/din in,
//           busy/done/dout[/carry] out)
// Parameters: WIDTH (>= 2) operand width; AMT_W amount width,
//             2**AMT_W >= WIDTH.
// Optional feature: define SEQ_SHIFTER_CARRY_EN to add the carry output,
// which holds the last bit shifted or rotated out.
// ---------------------------------------------------------------------------
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_shifter_if.slave bus
);

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_t           r_state;
    logic [AMT_W-1:0] r_count;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_dout;

    state_t           w_state_next;
    logic             w_load;
    logic [WIDTH-1:0] w_step_y;
    logic             w_out_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .x       (r_dout),
        .mode    (r_mode),
        .y       (w_step_y),
        .out_bit (w_out_bit)
    );

    // A request is taken in IDLE and also in DONE (back-to-back issue).
    assign w_load = bus.start && (r_state != ST_SHIFT);

    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start)
                    w_state_next = (bus.amount == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                // count is never 0 here: amount=0 bypasses SHIFT entirely.
                w_state_next = (r_count == CNT_ONE) ? ST_DONE : ST_SHIFT;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_mode  <= MODE_SHL;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_dout  <= bus.din;
                r_mode  <= bus.mode;
                r_count <= bus.amount;
            end else if (r_state == ST_SHIFT) begin
                r_dout  <= w_step_y;
                r_count <= r_count - CNT_ONE;
            end
        end
    end

`ifdef SEQ_SHIFTER_CARRY_EN
    logic r_carry;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_carry <= 1'b0;
        else if (w_load)
            r_carry <= 1'b0;
        else if (r_state == ST_SHIFT)
            r_carry <= w_out_bit;
    end

    assign bus.carry = r_carry;
`else
    // Out-bit is only consumed by the optional carry register.
    logic w_unused_out_bit;
    assign w_unused_out_bit = w_out_bit;
`endif

    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_DONE);
    assign bus.dout = r_dout;

endmodule

// File: tb/tb_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter: directed self-checking bench for seq_shifter (WIDTH=16,
// AMT_W=4). Carry checks are compiled in with SEQ_SHIFTER_CARRY_EN.
// ---------------------------------------------------------------------------
module tb_seq_shifter;
    import shift_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    seq_shifter_if #(.WIDTH(16), .AMT_W(4)) bus ();

    seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at a falling edge, let edge k sample it, return at
    // the falling edge after k with start low and the inputs scrambled so
    // that any late re-sampling would corrupt the result.
    task automatic issue(input logic [2:0] m, input logic [3:0] a, input logic [15:0] d);
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.amount = a;
        bus.din    = d;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mode   = 3'd1;
        bus.amount = 4'd9;
        bus.din    = 16'hDEAD;
    endtask

    // Count further clock edges until done is seen (bounded).
    task automatic wait_done(output int n, output int busy_cyc);
        n = 0;
        busy_cyc = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.busy === 1'b1) busy_cyc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        total++;
        if (bus.dout !== 16'h0000) begin
            bad++; $display("FAIL reset_dout: got %h want 0000", bus.dout);
        end
`ifdef SEQ_SHIFTER_CARRY_EN
        total++;
        if (bus.carry !== 1'b0) begin
            bad++; $display("FAIL reset_carry: got %b want 0", bus.carry);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_shl;
        int n, b;
        issue(MODE_SHL, 4'd1, 16'hC001);
        wait_done(n, b);
        total++;
        if (n != 1) begin
            bad++; $display("FAIL shl_latency: got %0d edges want 1", n);
        end
        total++;
        if (bus.dout !== 16'h8002) begin
            bad++; $display("FAIL shl_dout: got %h want 8002", bus.dout);
        end
`ifdef SEQ_SHIFTER_CARRY_EN
        total++;
        if (bus.carry !== 1'b1) begin
            bad++; $display("FAIL shl_carry: got %b want 1", bus.carry);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_asr;
        int n, b;
        issue(MODE_ASR, 4'd4, 16'h8000);
        wait_done(n, b);
        total++;
        if (n != 4) begin
            bad++; $display("FAIL asr_latency: got %0d edges want 4", n);
        end
        total++;
        if (b != 4) begin
            bad++; $display("FAIL asr_busy_cycles: got %0d want 4", b);
        end
        total++;
        if (bus.dout !== 16'hF800) begin
            bad++; $display("FAIL asr_dout: got %h want f800", bus.dout);
        end
        @(negedge clk);
    endtask

    task automatic test_ror;
        int n, b;
        issue(MODE_ROR, 4'd15, 16'h0001);
        wait_done(n, b);
        total++;
        if (n != 15) begin
            bad++; $display("FAIL ror_latency: got %0d edges want 15", n);
        end
        total++;
        if (bus.dout !== 16'h0002) begin
            bad++; $display("FAIL ror_dout: got %h want 0002", bus.dout);
        end
`ifdef SEQ_SHIFTER_CARRY_EN
        total++;
        if (bus.carry !== 1'b0) begin
            bad++; $display("FAIL ror_carry: got %b want 0", bus.carry);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_shr_zero;
        int n, b;
        issue(MODE_SHR, 4'd0, 16'hABCD);
        wait_done(n, b);
        total++;
        if (n != 0 || b != 0) begin
            bad++; $display("FAIL shr0_timing: got %0d edges %0d busy want 0 0", n, b);
        end
        total++;
        if (bus.dout !== 16'hABCD) begin
            bad++; $display("FAIL shr0_dout: got %h want abcd", bus.dout);
        end
`ifdef SEQ_SHIFTER_CARRY_EN
        total++;
        if (bus.carry !== 1'b0) begin
            bad++; $display("FAIL shr0_carry: got %b want 0", bus.carry);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_rol_ignore;
        int n, b;
        issue(MODE_ROL, 4'd8, 16'h1234);   // edge k
        @(negedge clk);                    // after k+1
        @(negedge clk);                    // after k+2
        bus.start  = 1'b1;                 // sampled at k+3 while busy
        bus.mode   = MODE_SHL;
        bus.amount = 4'd1;
        bus.din    = 16'hFFFF;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(n, b);
        total++;
        if (n != 5) begin
            bad++; $display("FAIL rol_latency: got %0d extra edges want 5", n);
        end
        total++;
        if (bus.dout !== 16'h3412) begin
            bad++; $display("FAIL rol_dout: got %h want 3412", bus.dout);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dout !== 16'h3412) begin
            bad++; $display("FAIL idle_hold: done=%b busy=%b dout=%h want 0 0 3412",
                            bus.done, bus.busy, bus.dout);
        end
    endtask

    task automatic test_reset_abort;
        int pulses;
        issue(MODE_ROL, 4'd8, 16'h1234);   // edge k
        repeat (3) @(negedge clk);         // after k+3
        rst_n = 1'b0;                      // sampled at k+4
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.dout !== 16'h0000 || bus.done !== 1'b0) begin
            bad++; $display("FAIL abort_state: busy=%b done=%b dout=%h want 0 0 0000",
                            bus.busy, bus.done, bus.dout);
        end
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL abort_no_done: got %0d done pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int n, b;
        issue(MODE_SHL, 4'd1, 16'hC001);
        wait_done(n, b);
        // Now in DONE: issue the next request immediately.
        issue(3'd7, 4'd2, 16'h5A5A);
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        wait_done(n, b);
        total++;
        if (n != 2) begin
            bad++; $display("FAIL b2b_latency: got %0d edges want 2", n);
        end
        total++;
        if (bus.dout !== 16'h5A5A) begin
            bad++; $display("FAIL b2b_dout: got %h want 5a5a", bus.dout);
        end
`ifdef SEQ_SHIFTER_CARRY_EN
        total++;
        if (bus.carry !== 1'b0) begin
            bad++; $display("FAIL b2b_carry: got %b want 0", bus.carry);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.mode   = 3'd0;
        bus.amount = 4'd0;
        bus.din    = 16'h0000;
        @(negedge clk);
        test_reset();
        test_shl();
        test_asr();
        test_ror();
        test_shr_zero();
        test_rol_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
